// File: rtl/timer_cmd_tx_if.sv
// timer_cmd_tx_if: command handshake and receiver link of timer_cmd_tx
interface timer_cmd_tx_if;
  logic       cmd_valid;
  logic [3:0] cmd_delay;
  logic       cmd_ready;
  logic       data;
  logic       done;
  logic       ack;
  logic       busy;
  logic       timeout_err;
  modport master (output cmd_valid, cmd_delay, done, input cmd_ready, data, ack, busy, timeout_err);
  modport slave (input cmd_valid, cmd_delay, done, output cmd_ready, data, ack, busy, timeout_err);
endinterface

// File: rtl/timer_cmd_tx.sv
// timer_cmd_tx: serial timer-command transmitter (1101 + delay, done/ack, guard gap); watchdog under CMD_TX_TIMEOUT_EN
module timer_cmd_tx #(
  parameter int IDLE_GAP       = 2,
  parameter int TIMEOUT_CYCLES = 16000
) (
  input logic           clk,
  input logic           reset,
  timer_cmd_tx_if.slave bus
);
  typedef enum logic [3:0] {IDLE, H0, H1, H2, H3, D3, D2, D1, D0, WAIT_DONE, ACK, GAP} state_t;
  state_t     state, state_nx;
  logic [3:0] sr, gap_cnt;
  logic       to_hit;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sr      <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.cmd_valid) sr <= bus.cmd_delay;
      else if (state inside {D3, D2, D1, D0}) sr <= {sr[2:0], 1'b0};
      gap_cnt <= (state_nx == GAP && state != GAP) ? 4'(IDLE_GAP - 1) :
                 (gap_cnt != 4'd0) ? gap_cnt - 4'd1 : gap_cnt;
    end
  end
`ifdef CMD_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          terr;
  assign to_hit = tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
      terr <= 1'b0;
    end else begin
      tcnt <= (state == WAIT_DONE) ? tcnt + 1'b1 : '0;
      terr <= state == WAIT_DONE && !bus.done && to_hit;
    end
  end
  assign bus.timeout_err = terr;
`else
  logic unused_tc;
  assign unused_tc       = TIMEOUT_CYCLES > 0;
  assign to_hit          = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (bus.cmd_valid) state_nx = H0;
      H0:        state_nx = H1;
      H1:        state_nx = H2;
      H2:        state_nx = H3;
      H3:        state_nx = D3;
      D3:        state_nx = D2;
      D2:        state_nx = D1;
      D1:        state_nx = D0;
      D0:        state_nx = WAIT_DONE;
      WAIT_DONE: state_nx = bus.done ? ACK : to_hit ? GAP : WAIT_DONE;
      ACK:       state_nx = GAP;
      GAP:       if (gap_cnt == 4'd0) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    bus.cmd_ready = state == IDLE;
    bus.busy      = state != IDLE;
    bus.ack       = state == ACK;
    bus.data      = state inside {H0, H1, H3} || (state inside {D3, D2, D1, D0} && sr[3]);
  end
endmodule

// File: tb/tb_timer_cmd_tx.sv
// tb_timer_cmd_tx: table, hand-written and randomized checks of timer_cmd_tx against a frame timeline model
module tb_timer_cmd_tx;
  localparam int G  = 2;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  timer_cmd_tx_if bus();
  timer_cmd_tx #(.IDLE_GAP(G), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] d;
    int         w;
    bit         noise;
    bit         hv;
    bit         hd;
    logic [7:0] bits;
  } vec_t;
  vec_t tbl[5];
  function automatic logic [4:0] outs();
    return {bus.cmd_ready, bus.busy, bus.data, bus.ack, bus.timeout_err};
  endfunction
  // expected {ready,busy,data,ack,timeout_err} in cycle t after the accept edge
  function automatic logic [4:0] exp_out(int t, logic [7:0] bits, int w, bit to);
    int wl, gs;
    wl = to ? TO : w;
    gs = 9 + wl + (to ? 0 : 1);
    if (t <= 8) return {2'b01, bits[8-t], 2'b00};
    if (t <= 8 + wl) return 5'b01000;
    if (!to && t == 9 + wl) return 5'b01010;
    if (t < gs + G) return {4'b0100, to && t == gs};
    return 5'b10000;
  endfunction
  task automatic check(input string name, input int t, input logic [4:0] got, input logic [4:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s t=%0d got {rdy,busy,data,ack,terr}=%b want=%b", name, t, got, want);
    end
  endtask
  task automatic idle(input int n, input bit dn);
    for (int i = 0; i < n; i++) begin
      bus.done = dn;
      @(negedge clk);
      check("idle", i, outs(), 5'b10000);
    end
  endtask
  task automatic frame(input string name, input logic [7:0] bits, input int w, input bit to,
                       input bit noise, input bit hv, input bit hd);
    int wl, last;
    wl = to ? TO : w;
    last = 9 + wl + (to ? 0 : 1) + G;
    bus.cmd_valid = 1'b1;
    bus.cmd_delay = bits[3:0];
    @(posedge clk);
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      check(name, t, outs(), exp_out(t, bits, w, to));
      bus.cmd_valid = hv;
      if (t <= 8) bus.done = noise ? 1'($urandom) : 1'b0;
      else if (t <= 8 + wl) bus.done = !to && t == 8 + w;
      else if (t < last) bus.done = hd || (noise && 1'($urandom));
      else bus.done = noise && 1'($urandom);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog t=0 got=running want=finished");
    $fatal(1);
  end
  initial begin
    logic [3:0] d;
    bus.cmd_valid = 1'b0;
    bus.cmd_delay = 4'd0;
    bus.done      = 1'b0;
    tbl[0] = '{4'b1010, 6, 1'b0, 1'b0, 1'b1, 8'b1101_1010};
    tbl[1] = '{4'b0000, 2, 1'b1, 1'b0, 1'b0, 8'b1101_0000};
    tbl[2] = '{4'b1111, 1, 1'b1, 1'b0, 1'b0, 8'b1101_1111};
    tbl[3] = '{4'b0011, 2, 1'b0, 1'b1, 1'b0, 8'b1101_0011};
    tbl[4] = '{4'b1100, 2, 1'b0, 1'b0, 1'b0, 8'b1101_1100};
    repeat (3) @(posedge clk);
    #1 check("in_reset", 0, outs(), 5'b10000);
    @(negedge clk) reset = 1'b1;
    #1 check("after_reset", 0, outs(), 5'b10000);
    bus.cmd_valid = 1'b1;
    bus.cmd_delay = 4'b0100;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 check("d2_before_reset", 6, outs(), 5'b01100);
    reset = 1'b0;
    #1 check("async_reset", 6, outs(), 5'b10000);
    @(negedge clk) reset = 1'b1;
    #1 check("post_async_reset", 0, outs(), 5'b10000);
    idle(2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      frame("table", tbl[i].bits, tbl[i].w, 1'b0, tbl[i].noise, tbl[i].hv, tbl[i].hd);
      if (!tbl[i].hv) idle(2, 1'b1);
    end
`ifdef CMD_TX_TIMEOUT_EN
    frame("timeout", 8'b1101_0110, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    frame("done_at_limit", 8'b1101_1001, TO, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
`endif
    for (int i = 0; i < 30; i++) begin
      bit hv;
      d  = 4'($urandom);
      hv = 1'($urandom);
      frame("random", {4'b1101, d}, $urandom_range(1, 6), 1'b0, 1'($urandom), hv, 1'($urandom));
      if (!hv) idle($urandom_range(0, 3), 1'($urandom));
    end
    bus.cmd_valid = 1'b0;
    idle(2, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
